// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external ALU between two requesters.
// Define ALU_OPCHK_EN to answer illegal opcodes directly (W=0, Zero=1) without using the ALU.
module alu_share_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             ReqValid0,
  input  logic             ReqValid1,
  output logic             ReqReady0,
  output logic             ReqReady1,
  input  logic [WIDTH-1:0] ReqA0,
  input  logic [WIDTH-1:0] ReqA1,
  input  logic [WIDTH-1:0] ReqB0,
  input  logic [WIDTH-1:0] ReqB1,
  input  logic [3:0]       ReqCtrl0,
  input  logic [3:0]       ReqCtrl1,
  output logic             RespValid0,
  output logic             RespValid1,
  input  logic             RespReady0,
  input  logic             RespReady1,
  output logic [WIDTH-1:0] RespW,
  output logic             RespZero,
  output logic [WIDTH-1:0] ALUBusA,
  output logic [WIDTH-1:0] ALUBusB,
  output logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] ALUBusW,
  input  logic             ALUZero
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t r_state, w_next;
  logic r_last, r_owner;
  logic w_win, w_acc, w_done, w_bad;
  logic [WIDTH-1:0] w_a, w_b;
  logic [3:0] w_ctrl;
  // both valid: the requester that did not win last time goes first
  assign w_win  = ReqValid1 & (~ReqValid0 | ~r_last);
  assign w_acc  = (r_state == IDLE) & (ReqValid0 | ReqValid1);
  assign ReqReady0 = w_acc & ~w_win;
  assign ReqReady1 = w_acc & w_win;
  assign w_a    = w_win ? ReqA1 : ReqA0;
  assign w_b    = w_win ? ReqB1 : ReqB0;
  assign w_ctrl = w_win ? ReqCtrl1 : ReqCtrl0;
  assign w_done = (r_state == RESP) & (r_owner ? RespReady1 : RespReady0);
`ifdef ALU_OPCHK_EN
  assign w_bad = !(w_ctrl inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111});
`else
  assign w_bad = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? (w_bad ? RESP : ISSUE) : IDLE;
      ISSUE:   w_next = RESP;
      RESP:    w_next = w_done ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) r_state <= IDLE;
    else          r_state <= w_next;
  end
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      ALUBusA    <= '0;
      ALUBusB    <= '0;
      ALUCtrl    <= 4'b0000;
      RespW      <= '0;
      RespZero   <= 1'b0;
      RespValid0 <= 1'b0;
      RespValid1 <= 1'b0;
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
    end else begin
      if (w_acc) begin
        r_owner <= w_win;
        if (w_bad) begin
          RespW      <= '0;
          RespZero   <= 1'b1;
          RespValid0 <= ~w_win;
          RespValid1 <= w_win;
        end else begin
          ALUBusA <= w_a;
          ALUBusB <= w_b;
          ALUCtrl <= w_ctrl;
        end
      end
      if (r_state == ISSUE) begin
        RespW      <= ALUBusW;
        RespZero   <= ALUZero;
        RespValid0 <= ~r_owner;
        RespValid1 <= r_owner;
      end
      if (w_done) begin
        RespValid0 <= 1'b0;
        RespValid1 <= 1'b0;
        r_last     <= r_owner;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: random + directed stimulus, scoreboard monitor against a transaction-level arbiter/ALU model.
module tb_alu_share_arbiter;
  localparam int W = 64;
  logic CLK = 1'b0;
  logic Reset_L = 1'b0;
  logic rv[2];
  logic rr[2];
  logic [W-1:0] ra[2], rb[2];
  logic [3:0] rc[2];
  logic ReqReady0, ReqReady1, RespValid0, RespValid1, RespZero, ALUZero;
  logic [W-1:0] RespW, ALUBusA, ALUBusB, ALUBusW;
  logic [3:0] ALUCtrl;
  int tests = 0;
  int fails = 0;
  int rr_mode = 1;
  typedef struct {
    int n;
    logic [W-1:0] a, b, w;
    logic z;
    logic [3:0] c;
    int lat;
  } exp_t;
  exp_t sb[$];
  bit busy = 0;
  int m_last = 1;
  int age = 0;
  logic [1:0] exp_rdy, exp_vld;

  always #5 CLK = ~CLK;

  alu_share_arbiter #(.WIDTH(W)) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .ReqValid0(rv[0]), .ReqValid1(rv[1]),
    .ReqReady0(ReqReady0), .ReqReady1(ReqReady1),
    .ReqA0(ra[0]), .ReqA1(ra[1]), .ReqB0(rb[0]), .ReqB1(rb[1]),
    .ReqCtrl0(rc[0]), .ReqCtrl1(rc[1]),
    .RespValid0(RespValid0), .RespValid1(RespValid1),
    .RespReady0(rr[0]), .RespReady1(rr[1]),
    .RespW(RespW), .RespZero(RespZero),
    .ALUBusA(ALUBusA), .ALUBusB(ALUBusB), .ALUCtrl(ALUCtrl),
    .ALUBusW(ALUBusW), .ALUZero(ALUZero)
  );

  function automatic logic [W-1:0] alu_ref(logic [3:0] c, logic [W-1:0] a, logic [W-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic bit legal(logic [3:0] c);
    return c == 4'b0000 || c == 4'b0001 || c == 4'b0010 || c == 4'b0110 || c == 4'b0111;
  endfunction

  // external ALU instance seen by the arbiter
  assign ALUBusW = alu_ref(ALUCtrl, ALUBusA, ALUBusB);
  assign ALUZero = (ALUBusW == '0);

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(int n, logic [W-1:0] a, logic [W-1:0] b, logic [3:0] c);
    int k = 0;
    rv[n] = 1'b1; ra[n] = a; rb[n] = b; rc[n] = c;
    do begin
      @(negedge CLK);
      k++;
    end while (!(n == 1 ? ReqReady1 : ReqReady0) && k < 200);
    if (k >= 200) begin
      tests++; fails++;
      $display("FAIL accept_timeout: requester %0d got no ReqReady within 200 cycles", n);
    end
    @(posedge CLK);
    #1;
    rv[n] = 1'b0; ra[n] = {$urandom, $urandom}; rb[n] = {$urandom, $urandom}; rc[n] = 4'($urandom);
  endtask

  task automatic rand_req(int n);
    logic [W-1:0] a, b;
    logic [3:0] c;
    a = {$urandom, $urandom};
    b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) c = 4'($urandom_range(8, 15));
    else case ($urandom_range(0, 4))
      0: c = 4'b0000; 1: c = 4'b0001; 2: c = 4'b0010; 3: c = 4'b0110; default: c = 4'b0111;
    endcase
    drive_req(n, a, b, c);
  endtask

  initial begin
    rr[0] = 1'b0; rr[1] = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < 2; i++)
        rr[i] = (rr_mode == 1) ? 1'b1 : (rr_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // scoreboard monitor: transaction-level model of arbitration, latency and results
  always @(negedge CLK) begin
    if (!Reset_L) begin
      sb.delete(); busy = 0; m_last = 1; age = 0;
    end else begin
      if (busy) age++;
      exp_rdy = 2'b00;
      if (!busy && (rv[0] || rv[1])) begin
        if (!rv[1]) exp_rdy = 2'b01;
        else if (!rv[0]) exp_rdy = 2'b10;
        else exp_rdy = (m_last == 1) ? 2'b01 : 2'b10;
      end
      check("req_ready", W'({ReqReady1, ReqReady0}), W'(exp_rdy));
      exp_vld = (busy && sb.size() > 0 && age >= sb[0].lat) ? 2'(2'b01 << sb[0].n) : 2'b00;
      check("resp_valid", W'({RespValid1, RespValid0}), W'(exp_vld));
      if (busy && sb.size() > 0) begin
        if (age == 1 && sb[0].lat == 2) begin
          check("alu_bus_a", ALUBusA, sb[0].a);
          check("alu_bus_b", ALUBusB, sb[0].b);
          check("alu_ctrl", W'(ALUCtrl), W'(sb[0].c));
        end
        if (exp_vld != 2'b00) begin
          check("resp_w", RespW, sb[0].w);
          check("resp_zero", W'(RespZero), W'(sb[0].z));
          if (rr[sb[0].n]) begin
            m_last = sb[0].n;
            busy = 0;
            void'(sb.pop_front());
          end
        end
      end
      if (exp_rdy != 2'b00) begin
        exp_t e;
        e.n = exp_rdy[1] ? 1 : 0;
        e.a = ra[e.n]; e.b = rb[e.n]; e.c = rc[e.n];
        e.w = alu_ref(e.c, e.a, e.b);
        e.z = (e.w == '0);
        e.lat = 2;
`ifdef ALU_OPCHK_EN
        if (!legal(e.c)) begin e.w = '0; e.z = 1'b1; e.lat = 1; end
`endif
        sb.push_back(e);
        busy = 1;
        age = 0;
      end
    end
  end

  task automatic drain();
    int k = 0;
    while ((busy || sb.size() != 0) && k < 300) begin
      @(negedge CLK);
      k++;
    end
    check("drain_queue_empty", W'(sb.size()), '0);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_resp_valid"}, W'({RespValid1, RespValid0}), '0);
    check({tag, "_resp_w"}, RespW, '0);
    check({tag, "_resp_zero"}, W'(RespZero), '0);
    check({tag, "_alu_a"}, ALUBusA, '0);
    check({tag, "_alu_b"}, ALUBusB, '0);
    check({tag, "_alu_ctrl"}, W'(ALUCtrl), '0);
    check({tag, "_req_ready"}, W'({ReqReady1, ReqReady0}), '0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin rv[i] = 1'b0; ra[i] = '0; rb[i] = '0; rc[i] = '0; end
    repeat (2) @(posedge CLK);
    #1;
    check_outputs_zero("reset");
    Reset_L = 1'b1;
    rr_mode = 1;
    drive_req(0, 64'd5, 64'd3, 4'b0010);
    drive_req(1, 64'h1234, 64'h1234, 4'b0110);
    fork
      repeat (2) drive_req(0, 64'hF0, 64'h3C, 4'b0000);
      repeat (2) drive_req(1, 64'hF0, 64'h3C, 4'b0001);
    join
    drain();
    rr_mode = 2;
    fork
      drive_req(0, 64'd10, 64'd20, 4'b0010);
      begin repeat (3) @(posedge CLK); #1; drive_req(1, 64'd9, 64'd9, 4'b0110); end
      begin repeat (10) @(posedge CLK); #1; rr_mode = 1; end
    join
    drain();
    drive_req(0, 64'd1, 64'd2, 4'b1111);
    drain();
    rr_mode = 0;
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        #1;
        rand_req(0);
      end
      for (int j = 0; j < 30; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        #1;
        rand_req(1);
      end
    join
    rr_mode = 1;
    drain();
    drive_req(0, 64'd0, 64'd7, 4'b0111);
    #2;
    Reset_L = 1'b0;
    #1;
    check_outputs_zero("midop_reset");
    @(posedge CLK);
    #1;
    Reset_L = 1'b1;
    fork
      drive_req(0, 64'd9, 64'd4, 4'b0110);
      drive_req(1, 64'd9, 64'd4, 4'b0010);
    join
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU datapath (AND/OR/ADD/SUB/PassB, 4-bit ALUCtrl, Zero flag) between two requesters.
- Requester 0 is the execute-stage port; requester 1 is the address/aux port.
- Round-robin arbitration, valid/ready request handshake, registered operands, and a per-requester response handshake.
- Drives an external ALU instance and captures its result and Zero flag.

Parameters:
WIDTH, 64, operand/result width (ALU bus width)

Ports:
CLK  input  1  clock, all state rising-edge
Reset_L  input  1  reset, asynchronous assert, active-low
ReqValid0, ReqValid1  input  1 each  request valid per requester
ReqReady0, ReqReady1  output  1 each  request accepted this cycle
ReqA0, ReqA1  input  WIDTH each  operand A
ReqB0, ReqB1  input  WIDTH each  operand B
ReqCtrl0, ReqCtrl1  input  4 each  ALU opcode
RespValid0, RespValid1  output  1 each  result available
RespReady0, RespReady1  input  1 each  requester consumes result
RespW  output  WIDTH  registered result (shared, qualified by RespValidN)
RespZero  output  1  registered Zero flag
ALUBusA, ALUBusB  output  WIDTH each  registered operands to ALU
ALUCtrl  output  4  registered opcode to ALU
ALUBusW  input  WIDTH  ALU result
ALUZero  input  1  ALU Zero flag

Behaviour:
- Opcodes: AND 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110, PassB 4'b0111. All other values are illegal.
- Reset (Reset_L=0, asynchronous):
  - state=IDLE.
  - ALUBusA=0, ALUBusB=0, ALUCtrl=4'b0000.
  - RespW=0, RespZero=0, RespValid0/1=0.
  - LastGrant=1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Winner: if only one ReqValid is high, that requester wins. If both are high, the requester != LastGrant wins.
  - ReqReadyN = (state==IDLE) & winner==N. This is combinational from ReqValid; at most one ReqReady is high per cycle.
  - On accept: latch ReqA/ReqB/ReqCtrl of the winner into ALUBusA/ALUBusB/ALUCtrl, record Owner=N, go to ISSUE.
  - No valid: stay in IDLE; ALU regs hold.
- ISSUE (1 cycle): the ALU settles on the registered operands. At the clock edge, RespW<=ALUBusW, RespZero<=ALUZero, RespValidOwner<=1; go to RESP.
- RESP:
  - RespValidOwner stays high, and RespW/RespZero stay stable, until RespReadyOwner=1 at a clock edge.
  - On that edge: RespValidOwner<=0, LastGrant<=Owner, go to IDLE.
  - The other requester's RespValid stays 0.
- Latency and throughput:
  - Accept edge t -> RespValid high after edge t+1 (2 cycles).
  - Minimum 3 cycles per op with RespReady tied high; no overlap between ops.
- Requester obligations: hold ReqValid/ReqA/ReqB/ReqCtrl stable until ReqReady. ReqValid drop before accept is allowed and nothing is latched.
- Starvation-free: with both requesters continuously valid, grants alternate 0,1,0,1.
- Width: no carry/overflow output. ADD/SUB wrap modulo 2^WIDTH (ALU behaviour, passed through untouched).
- Reset mid-operation: the in-flight op is dropped with no response, and LastGrant returns to 1.
- RespReadyN asserted while RespValidN=0 is ignored.

Optional Feature:
- Macro ALU_OPCHK_EN.
- Defined:
  - An illegal ReqCtrl is still accepted (ReqReady per normal rules), but the ALU regs are not loaded.
  - FSM goes IDLE->RESP directly, with RespW=0 and RespZero=1 (1-cycle latency).
  - Round-robin update is unchanged.
- Undefined: the opcode is forwarded unchanged to ALUCtrl, and RespW/RespZero are whatever the ALU returns.

Test Plan:
- Reset then ReqValid0=1, A=5, B=3, Ctrl=ADD, RespReady0=1 -> ReqReady0 in cycle 1; RespValid0=1 two cycles later; RespW=8, RespZero=0.
- Req1 SUB A=B=64'h1234 -> RespW=0, RespZero=1; RespValid1 only, RespValid0 stays 0.
- Both valid continuously (Req0 AND A=F0 B=3C, Req1 OR same operands) for 4 ops -> grant order 0,1,0,1; results 30, FC, 30, FC.
- RespReady0 held low 5 cycles after RespValid0 -> RespValid0/RespW stable 5 cycles; no ReqReady to pending Req1 until release.
- Reset_L low in ISSUE with Req0 PassB B=7 -> all outputs 0 immediately; after release, next op is granted to requester 0.
- Ctrl=4'b1111, A=1, B=2 -> with ALU_OPCHK_EN: RespValid one cycle after accept, RespW=0, RespZero=1; without it: ALUCtrl=4'b1111 observed on the ALU port.
